// File: rtl/lsu_if.sv
// Request/response and memory-side signal bundle for the load/store unit.
//   slave  : load_store_unit side (consumes requests, drives memory strobes)
//   master : requester / memory-model side
// Parameters: XLEN (data width, 32 or 64), ADDR_W (byte-address width).
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  // Response channel
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  // Memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  mem_rdata, mem_resp,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_address, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    output mem_rdata, mem_resp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV-style load or store, performs one or two
// aligned memory accesses, and returns an extended load result or an error.
// Ports:
//   clk      : clock, all state changes on rising edge
//   rst      : synchronous active-high reset
//   bus      : lsu_if.slave -- req_*/resp_* handshake and mem_* port
// Optional feature: define LSU_MISALIGN_EN to service misaligned accesses
// (split into two accesses); otherwise misaligned accesses are rejected.
module load_store_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);
  localparam int unsigned BEN   = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BEN);
  localparam int unsigned SH_W  = OFF_W + 3;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;
  state_t state, state_nxt;

  // Registered outputs and their next values
  logic              req_ready_q, resp_valid_q, resp_err_q, mem_read_q, mem_write_q;
  logic              resp_valid_nxt, resp_err_nxt, mem_read_nxt, mem_write_nxt;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_nxt, mem_wdata_q, mem_wdata_nxt;
  logic [ADDR_W-1:0] mem_address_q, mem_address_nxt;
  logic [BEN-1:0]    mem_wmask_q, mem_wmask_nxt;

  // Request latched on acceptance, plus low word of a split load
  logic              lat_store;
  logic [2:0]        lat_f3;
  logic [OFF_W-1:0]  lat_off;
  logic [XLEN-1:0]   lat_wdata;
  logic [XLEN-1:0]   rbuf, rbuf_nxt;

  // Sign- or zero-extend the low (8 << f3[1:0]) bits of raw to XLEN
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input logic [2:0] f3);
    int unsigned     bits;
    int unsigned     sh;
    logic [XLEN-1:0] t;
    bits = 32'(8) << f3[1:0];
    if (bits >= 32'(XLEN)) return raw;
    sh = 32'(XLEN) - bits;
    t  = raw << sh;
    if (f3[2]) t = t >> sh;
    else       t = $signed(t) >>> sh;
    return t;
  endfunction

  // Decode source: live request in IDLE, latched request afterwards
  logic             src_store;
  logic [2:0]       src_f3;
  logic [OFF_W-1:0] src_off;
  logic [XLEN-1:0]  src_wdata;

  always_comb begin
    if (state == IDLE) begin
      src_store = bus.req_store;
      src_f3    = bus.req_funct3;
      src_off   = bus.req_addr[OFF_W-1:0];
      src_wdata = bus.req_wdata;
    end else begin
      src_store = lat_store;
      src_f3    = lat_f3;
      src_off   = lat_off;
      src_wdata = lat_wdata;
    end
  end

  // Lane placement over a double-width window: low half feeds the first
  // access, high half holds the bytes that spill into the next word.
  logic [3:0]        size_bytes;
  logic [SH_W-1:0]   sh_bits;
  logic [2*BEN-1:0]  wide_mask;
  logic [2*XLEN-1:0] wide_data;
  logic              split, illegal, reject;
  logic [XLEN-1:0]   load_lo, load_hi;

  assign size_bytes = 4'(1) << src_f3[1:0];
  assign sh_bits    = {src_off, 3'b000};
  assign wide_mask  = (((2*BEN)'(1) << size_bytes) - (2*BEN)'(1)) << src_off;
  assign wide_data  = {XLEN'(0), extend(src_wdata, {1'b1, src_f3[1:0]})} << sh_bits;
  assign split      = |wide_mask[2*BEN-1:BEN];

  assign illegal = (src_f3 == 3'b111) ||
                   (src_store && src_f3[2]) ||
                   ((XLEN == 32) && ((src_f3 == 3'b011) || (src_f3 == 3'b110)));

`ifdef LSU_MISALIGN_EN
  assign reject = illegal;
`else
  logic misaligned;
  assign misaligned = |(src_off & OFF_W'(size_bytes - 4'd1));
  assign reject     = illegal | misaligned;
`endif

  // Little-endian assembly: unsplit uses one word, split joins both words
  assign load_lo = extend(XLEN'(bus.mem_rdata >> sh_bits), src_f3);
  assign load_hi = extend(XLEN'({bus.mem_rdata, rbuf} >> sh_bits), src_f3);

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    resp_valid_nxt  = 1'b0;
    resp_err_nxt    = 1'b0;
    resp_rdata_nxt  = resp_rdata_q;
    mem_read_nxt    = mem_read_q;
    mem_write_nxt   = mem_write_q;
    mem_address_nxt = mem_address_q;
    mem_wdata_nxt   = mem_wdata_q;
    mem_wmask_nxt   = mem_wmask_q;
    rbuf_nxt        = rbuf;
    case (state)
      IDLE: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        if (bus.req_valid) begin
          if (reject) begin
            state_nxt      = DONE;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = '0;
          end else begin
            state_nxt       = ACC1;
            mem_read_nxt    = !src_store;
            mem_write_nxt   = src_store;
            mem_address_nxt = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            mem_wdata_nxt   = wide_data[XLEN-1:0];
            mem_wmask_nxt   = wide_mask[BEN-1:0];
          end
        end
      end
      ACC1: begin
        if (bus.mem_resp) begin
          if (split) begin
            state_nxt       = ACC2;
            mem_address_nxt = mem_address_q + ADDR_W'(BEN);
            mem_wdata_nxt   = wide_data[2*XLEN-1:XLEN];
            mem_wmask_nxt   = wide_mask[2*BEN-1:BEN];
            rbuf_nxt        = bus.mem_rdata;
          end else begin
            state_nxt      = DONE;
            resp_valid_nxt = 1'b1;
            resp_rdata_nxt = src_store ? '0 : load_lo;
            mem_read_nxt   = 1'b0;
            mem_write_nxt  = 1'b0;
            mem_wdata_nxt  = '0;
            mem_wmask_nxt  = '0;
          end
        end
      end
      ACC2: begin
        if (bus.mem_resp) begin
          state_nxt      = DONE;
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = src_store ? '0 : load_hi;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
          mem_wdata_nxt  = '0;
          mem_wmask_nxt  = '0;
        end
      end
      DONE: state_nxt = IDLE;
      default: begin
        state_nxt     = IDLE;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase
  end

  // State, output and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      rbuf          <= '0;
      lat_store     <= 1'b0;
      lat_f3        <= '0;
      lat_off       <= '0;
      lat_wdata     <= '0;
    end else begin
      state         <= state_nxt;
      req_ready_q   <= (state_nxt == IDLE);
      resp_valid_q  <= resp_valid_nxt;
      resp_err_q    <= resp_err_nxt;
      resp_rdata_q  <= resp_rdata_nxt;
      mem_read_q    <= mem_read_nxt;
      mem_write_q   <= mem_write_nxt;
      mem_address_q <= mem_address_nxt;
      mem_wdata_q   <= mem_wdata_nxt;
      mem_wmask_q   <= mem_wmask_nxt;
      rbuf          <= rbuf_nxt;
      if (state == IDLE && bus.req_valid) begin
        lat_store <= bus.req_store;
        lat_f3    <= bus.req_funct3;
        lat_off   <= bus.req_addr[OFF_W-1:0];
        lat_wdata <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wmask   = mem_wmask_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit at XLEN=32.
module tb_load_store_unit;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_D = 3'b011;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_WU = 3'b110, F_BAD = 3'b111;

  logic clk;
  logic rst;
  lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

  load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Results captured by run_req
  logic [31:0] r_rdata;
  logic        r_err, r_strobe, r_wr;
  int          r_lat, r_nacc;
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [3:0]  r_mask [2];

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and act as memory: each access answers after 'waits'
  // idle cycles with d0 (first access) or d1 (second access).
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] d0,
                         input logic [31:0] d1, input int waits);
    int w;
    int acc;
    w = 0; acc = 0;
    r_strobe = 1'b0; r_wr = 1'b0; r_err = 1'b0; r_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_mask[i] = '0;
    end
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    cyc();
    // Scramble request fields; the DUT must use its latched copy
    bus.req_valid = 1'b0; bus.req_store = ~st; bus.req_funct3 = F_BAD;
    bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = 32'h5A5A_5A5A;
    r_lat = 1;
    while (!bus.resp_valid && r_lat < 50) begin
      if (bus.mem_read || bus.mem_write) begin
        r_strobe = 1'b1;
        if (bus.mem_write) r_wr = 1'b1;
        if (w == 0 && acc < 2) begin
          r_addr[acc] = bus.mem_address; r_wdata[acc] = bus.mem_wdata; r_mask[acc] = bus.mem_wmask;
        end
        if (w >= waits) begin
          bus.mem_resp = 1'b1; bus.mem_rdata = (acc == 0) ? d0 : d1;
          acc++; w = 0;
        end else begin
          bus.mem_resp = 1'b0; w++;
        end
      end else begin
        bus.mem_resp = 1'b0;
      end
      cyc();
      r_lat++;
    end
    bus.mem_resp = 1'b0;
    if (bus.resp_valid) begin
      r_rdata = bus.resp_rdata; r_err = bus.resp_err;
    end else begin
      r_lat = -1;
    end
    r_nacc = acc;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mem_resp = 1'b1; bus.mem_rdata = 32'h1234_5678;
    cyc(); cyc();
    rst = 1'b0;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
    n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
    n_tests++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {bus.mem_read, bus.mem_write}); end
    n_tests++; if (bus.mem_wmask !== 4'h0) begin n_fail++; $display("FAIL reset_wmask: got %b want 0000", bus.mem_wmask); end
    n_tests++; if (bus.mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", bus.mem_address); end
    n_tests++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    // Stray mem_resp in IDLE must do nothing
    cyc();
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_stray_resp: resp_valid got %b want 0", bus.resp_valid); end
    bus.mem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_lw();
    run_req(1'b0, F_W, 32'h100, 32'h0, 32'h8BAD_F00D, 32'h0, 2);
    n_tests++; if (r_lat !== 4) begin n_fail++; $display("FAIL lw_latency: got %0d want 4", r_lat); end
    n_tests++; if (r_addr[0] !== 32'h100) begin n_fail++; $display("FAIL lw_address: got %h want 00000100", r_addr[0]); end
    n_tests++; if (r_rdata !== 32'h8BAD_F00D) begin n_fail++; $display("FAIL lw_rdata: got %h want 8badf00d", r_rdata); end
    n_tests++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", r_err); end
    n_tests++; if (r_wr !== 1'b0) begin n_fail++; $display("FAIL lw_no_write: got %b want 0", r_wr); end
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL done_req_ready: got %b want 0", bus.req_ready); end
    // Stray mem_resp in DONE ignored; rdata held; back to IDLE
    bus.mem_resp = 1'b1;
    cyc();
    bus.mem_resp = 1'b0;
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_pulse_width: resp_valid got %b want 0", bus.resp_valid); end
    n_tests++; if (bus.resp_rdata !== 32'h8BAD_F00D) begin n_fail++; $display("FAIL lw_rdata_hold: got %h want 8badf00d", bus.resp_rdata); end
    n_tests++; if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL lw_back_idle: ready %b read %b want 1 0", bus.req_ready, bus.mem_read); end
  endtask

  task automatic test_sub_word_loads();
    run_req(1'b0, F_B, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 0);
    n_tests++; if (r_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", r_rdata); end
    n_tests++; if (r_lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", r_lat); end
    cyc();
    run_req(1'b0, F_BU, 32'h103, 32'h0, 32'h8000_0000, 32'h0, 0);
    n_tests++; if (r_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", r_rdata); end
    cyc();
    run_req(1'b0, F_H, 32'h102, 32'h0, 32'h8001_1234, 32'h0, 1);
    n_tests++; if (r_rdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_rdata: got %h want ffff8001", r_rdata); end
    n_tests++; if (r_mask[0] !== 4'b1100) begin n_fail++; $display("FAIL lh_mask: got %b want 1100", r_mask[0]); end
    cyc();
    run_req(1'b0, F_HU, 32'h102, 32'h0, 32'h8001_1234, 32'h0, 0);
    n_tests++; if (r_rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_rdata: got %h want 00008001", r_rdata); end
    cyc();
  endtask

  task automatic test_stores();
    run_req(1'b1, F_H, 32'h102, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0, 1);
    n_tests++; if (r_addr[0] !== 32'h100) begin n_fail++; $display("FAIL sh_address: got %h want 00000100", r_addr[0]); end
    n_tests++; if (r_mask[0] !== 4'b1100) begin n_fail++; $display("FAIL sh_mask: got %b want 1100", r_mask[0]); end
    n_tests++; if (r_wdata[0] !== 32'hBEEF_0000) begin n_fail++; $display("FAIL sh_wdata: got %h want beef0000", r_wdata[0]); end
    n_tests++; if (r_wr !== 1'b1) begin n_fail++; $display("FAIL sh_write_strobe: got %b want 1", r_wr); end
    n_tests++; if (r_rdata !== 32'h0) begin n_fail++; $display("FAIL sh_rdata_zero: got %h want 0", r_rdata); end
    n_tests++; if (r_lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", r_lat); end
    cyc();
    run_req(1'b1, F_B, 32'h201, 32'h0000_00AB, 32'h0, 32'h0, 0);
    n_tests++; if (r_mask[0] !== 4'b0010 || (r_wdata[0] & 32'h0000_FF00) !== 32'h0000_AB00) begin
      n_fail++; $display("FAIL sb_lane: mask %b wdata %h want 0010 0000ab00", r_mask[0], r_wdata[0]);
    end
    n_tests++; if (r_addr[0] !== 32'h200) begin n_fail++; $display("FAIL sb_address: got %h want 00000200", r_addr[0]); end
    cyc();
  endtask

  task automatic test_illegal();
    logic [3:0] codes [4];
    codes[0] = {1'b0, F_BAD}; codes[1] = {1'b0, F_D}; codes[2] = {1'b0, F_WU}; codes[3] = {1'b1, F_BU};
    for (int i = 0; i < 4; i++) begin
      run_req(codes[i][3], codes[i][2:0], 32'h300, 32'h0, 32'h0, 32'h0, 0);
      n_tests++; if (r_err !== 1'b1 || r_strobe !== 1'b0 || r_lat !== 1) begin
        n_fail++; $display("FAIL illegal_%0d: err %b strobe %b lat %0d want 1 0 1", i, r_err, r_strobe, r_lat);
      end
      cyc();
    end
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_EN
    run_req(1'b0, F_W, 32'h102, 32'h0, 32'h1122_3344, 32'h5566_7788, 1);
    n_tests++; if (r_rdata !== 32'h7788_1122) begin n_fail++; $display("FAIL mis_lw_rdata: got %h want 77881122", r_rdata); end
    n_tests++; if (r_nacc !== 2 || r_addr[0] !== 32'h100 || r_addr[1] !== 32'h104) begin
      n_fail++; $display("FAIL mis_lw_addrs: n %0d a0 %h a1 %h want 2 100 104", r_nacc, r_addr[0], r_addr[1]);
    end
    n_tests++; if (r_lat !== 5) begin n_fail++; $display("FAIL mis_lw_latency: got %0d want 5", r_lat); end
    cyc();
    run_req(1'b1, F_W, 32'h103, 32'hAABB_CCDD, 32'h0, 32'h0, 0);
    n_tests++; if (r_addr[0] !== 32'h100 || r_mask[0] !== 4'b1000 || r_wdata[0] !== 32'hDD00_0000) begin
      n_fail++; $display("FAIL mis_sw_first: a %h m %b d %h want 100 1000 dd000000", r_addr[0], r_mask[0], r_wdata[0]);
    end
    n_tests++; if (r_addr[1] !== 32'h104 || r_mask[1] !== 4'b0111 || r_wdata[1] !== 32'h00AA_BBCC) begin
      n_fail++; $display("FAIL mis_sw_second: a %h m %b d %h want 104 0111 00aabbcc", r_addr[1], r_mask[1], r_wdata[1]);
    end
    cyc();
    run_req(1'b0, F_H, 32'h103, 32'h0, 32'h1122_3344, 32'h5566_7788, 0);
    n_tests++; if (r_rdata !== 32'hFFFF_8811) begin n_fail++; $display("FAIL mis_lh_rdata: got %h want ffff8811", r_rdata); end
    cyc();
`else
    run_req(1'b0, F_W, 32'h102, 32'h0, 32'h1122_3344, 32'h5566_7788, 0);
    n_tests++; if (r_err !== 1'b1 || r_strobe !== 1'b0) begin n_fail++; $display("FAIL mis_lw_reject: err %b strobe %b want 1 0", r_err, r_strobe); end
    n_tests++; if (r_lat !== 1) begin n_fail++; $display("FAIL mis_lw_latency: got %0d want 1", r_lat); end
    cyc();
    run_req(1'b1, F_W, 32'h103, 32'hAABB_CCDD, 32'h0, 32'h0, 0);
    n_tests++; if (r_err !== 1'b1 || r_strobe !== 1'b0) begin n_fail++; $display("FAIL mis_sw_reject: err %b strobe %b want 1 0", r_err, r_strobe); end
    cyc();
    run_req(1'b0, F_H, 32'h101, 32'h0, 32'h0, 32'h0, 0);
    n_tests++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL mis_lh_reject: err %b want 1", r_err); end
    cyc();
`endif
    // Aligned halfword in the upper lanes is never an error
    run_req(1'b0, F_HU, 32'h106, 32'h0, 32'hCAFE_0000, 32'h0, 0);
    n_tests++; if (r_err !== 1'b0 || r_rdata !== 32'h0000_CAFE) begin
      n_fail++; $display("FAIL aligned_lhu: err %b rdata %h want 0 0000cafe", r_err, r_rdata);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F_W; bus.req_addr = 32'h200;
    cyc();
    bus.req_valid = 1'b0;
    n_tests++; if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL mid_read_active: got %b want 1", bus.mem_read); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.mem_resp = 1'b1; bus.mem_rdata = 32'hDEAD_DEAD;
    n_tests++; if (bus.mem_read !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_abandon: read %b ready %b want 0 1", bus.mem_read, bus.req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++; if (bus.resp_valid !== 1'b0 || bus.mem_read !== 1'b0) begin
        n_fail++; $display("FAIL mid_stray_%0d: resp_valid %b read %b want 0 0", i, bus.resp_valid, bus.mem_read);
      end
    end
    bus.mem_resp = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, F_W, 32'h400, 32'h0, 32'h0102_0304, 32'h0, 0);
    n_tests++; if (r_rdata !== 32'h0102_0304) begin n_fail++; $display("FAIL b2b_first: got %h want 01020304", r_rdata); end
    cyc();
    run_req(1'b0, F_B, 32'h401, 32'h0, 32'h0102_0304, 32'h0, 0);
    n_tests++; if (r_rdata !== 32'h0000_0003 || r_lat !== 2) begin
      n_fail++; $display("FAIL b2b_second: rdata %h lat %0d want 00000003 2", r_rdata, r_lat);
    end
    cyc();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_illegal();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
